mem_stage_access_unit: RTL

//   MEM-stage consumer of the EX/MEM pipeline register in the 5-stage MIPS core.

---
 rtl/mem_stage_access_unit_if.sv | 14 +
 rtl/mem_stage_access_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface mem_stage_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM stage of the 5-stage MIPS core: variable-latency load/store over a req/ack bus, stall and branch resolve.
// Optional MEM_ALIGN_CHECK_EN: reject word-misaligned accesses with a misalign_o pulse instead of a request.
module mem_stage_access_unit #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read_i,
    input  logic                mem_write_i,
    input  logic                branch_i,
    input  logic                reg_write_i,
    input  logic                mem_to_reg_i,
    input  logic [DATA_W-1:0]   add1_i,
    input  logic                zero_i,
    input  logic [DATA_W-1:0]   alu_result_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [REG_W-1:0]    rd_i,
    mem_stage_access_unit_if.master dmem,
    output logic                stall_o,
    output logic                pc_src_o,
    output logic [DATA_W-1:0]   branch_target_o,
    output logic                bus_err_o,
    output logic                misalign_o,
    output logic [DATA_W-1:0]   wb_rdata_o,
    output logic [DATA_W-1:0]   wb_alu_o,
    output logic [REG_W-1:0]    wb_rd_o,
    output logic                wb_reg_write_o,
    output logic                wb_mem_to_reg_o
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_to_reg;
    } wb_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              req_q, req_nxt;
    logic              we_q, we_nxt;
    logic [DATA_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    wb_t               wb_q, wb_nxt, wb_in;
    logic              bus_err_q, bus_err_nxt;
    logic              access, misaligned;

    assign access = mem_read_i | mem_write_i;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    assign misaligned = access & (alu_result_i[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= (state == IDLE) & misaligned;
    end

    assign misalign_o = misalign_q;
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // MEM/WB image of the instruction currently held in EX/MEM
    always_comb begin
        wb_in            = '0;
        wb_in.alu        = alu_result_i;
        wb_in.rd         = rd_i;
        wb_in.reg_write  = reg_write_i;
        wb_in.mem_to_reg = mem_to_reg_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wb_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_q     <= req_nxt;
            we_q      <= we_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            wb_q      <= wb_nxt;
            bus_err_q <= bus_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        req_nxt     = req_q;
        we_nxt      = we_q;
        addr_nxt    = addr_q;
        wdata_nxt   = wdata_q;
        wb_nxt      = wb_q;
        bus_err_nxt = 1'b0;
        stall_o     = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    wb_nxt           = wb_in;
                    wb_nxt.reg_write = 1'b0;
                end else if (access) begin
                    state_nxt        = BUSY;
                    cnt_nxt          = '0;
                    req_nxt          = 1'b1;
                    we_nxt           = mem_write_i;
                    addr_nxt         = alu_result_i;
                    wdata_nxt        = wdata_i;
                    wb_nxt.reg_write = 1'b0;
                    stall_o          = 1'b1;
                end else begin
                    wb_nxt = wb_in;
                end
            end
            BUSY: begin
                if (dmem.ack) begin
                    state_nxt    = IDLE;
                    cnt_nxt      = '0;
                    req_nxt      = 1'b0;
                    wb_nxt       = wb_in;
                    wb_nxt.rdata = we_q ? '0 : dmem.rdata;
                end else if (cnt == CNT_W'(MAX_WAIT)) begin
                    // abort: the instruction leaves EX/MEM as a bubble
                    state_nxt        = IDLE;
                    cnt_nxt          = '0;
                    req_nxt          = 1'b0;
                    bus_err_nxt      = 1'b1;
                    wb_nxt.reg_write = 1'b0;
                end else begin
                    cnt_nxt          = cnt + 1'b1;
                    wb_nxt.reg_write = 1'b0;
                    stall_o          = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;

    assign pc_src_o        = branch_i & zero_i & ~stall_o;
    assign branch_target_o = add1_i;
    assign bus_err_o       = bus_err_q;

    assign wb_rdata_o      = wb_q.rdata;
    assign wb_alu_o        = wb_q.alu;
    assign wb_rd_o         = wb_q.rd;
    assign wb_reg_write_o  = wb_q.reg_write;
    assign wb_mem_to_reg_o = wb_q.mem_to_reg;
endmodule
